ex_mem_stage: RTL and testbench

//  Execute stage plus EX/MEM pipeline register. Consumes the packed ID/EX bundle and computes the ALU result.

---
 rtl/mips_pkg.sv | 52 +++++
 rtl/multu_seq.sv | 79 +++++++
 rtl/ex_mem_stage.sv | 134 +++++++++++++
 tb/tb_ex_mem_stage.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline definitions: ID/EX and EX/MEM bundle field offsets, ALU opcodes,
// R-type function codes and the execute-stage multiplier state type.
package mips_pkg;

    // ID/EX bundle field offsets (LSB positions)
    localparam int unsigned IDEX_RS_VAL   = 0;
    localparam int unsigned IDEX_RT_VAL   = 32;
    localparam int unsigned IDEX_ALUOP    = 64;
    localparam int unsigned IDEX_FUNCT    = 66;
    localparam int unsigned IDEX_RD       = 72;
    localparam int unsigned IDEX_REGWRITE = 77;
    localparam int unsigned IDEX_MEMREAD  = 78;
    localparam int unsigned IDEX_MEMWRITE = 79;
    localparam int unsigned IDEX_IMM      = 80;
    localparam int unsigned IDEX_RT       = 112;
    localparam int unsigned IDEX_ALUSRC   = 117;
    localparam int unsigned IDEX_MEMTOREG = 118;
    localparam int unsigned IDEX_REGDST   = 119;
    localparam int unsigned IDEX_RS       = 120;

    // EX/MEM bundle field offsets (LSB positions)
    localparam int unsigned EXMEM_RESULT   = 0;
    localparam int unsigned EXMEM_STORE    = 32;
    localparam int unsigned EXMEM_DEST     = 64;
    localparam int unsigned EXMEM_REGWRITE = 69;
    localparam int unsigned EXMEM_MEMREAD  = 70;
    localparam int unsigned EXMEM_MEMWRITE = 71;
    localparam int unsigned EXMEM_MEMTOREG = 72;
    localparam int unsigned EXMEM_ZERO     = 73;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    localparam logic [5:0] FUNCT_SLL   = 6'h00;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } ex_state_t;

endpackage

// File: rtl/multu_seq.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// done strobes in the final iteration while hi_out/lo_out carry the finished product.
module multu_seq
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out
);

    localparam int unsigned      CNT_W     = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    ex_state_t           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   mcand_q, mcand_d;
    logic [2*DATA_W-1:0] prod_q, prod_d;
    logic [DATA_W:0]     sum;
    logic                last;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mcand_d = mcand_q;
        prod_d  = prod_q;
        last    = 1'b0;
        // Upper half accumulates; lower half holds the multiplier bits still to consume.
        sum     = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    mcand_d = a;
                    prod_d  = {{DATA_W{1'b0}}, b};
                end
            end
            BUSY: begin
                prod_d = {sum, prod_q[DATA_W-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    last    = 1'b1;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mcand_q <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
        end
    end

    assign busy   = (state_q == BUSY);
    assign done   = last;
    assign hi_out = prod_d[2*DATA_W-1:DATA_W];
    assign lo_out = prod_d[DATA_W-1:0];

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM pipeline register: single-cycle ALU plus an iterative MULTU
// into HI/LO that stalls the upstream stages while it runs.
module ex_mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned IDEX_W  = 125,
    parameter int unsigned EXMEM_W = 74
) (
    input  logic               clock,
    input  logic               rst,
    input  logic [IDEX_W-1:0]  idex,
    input  logic [31:0]        idex_instruction,
    output logic [EXMEM_W-1:0] exmem,
    output logic [31:0]        exmem_instruction,
    output logic               ex_stall,
    output logic [DATA_W-1:0]  hi,
    output logic [DATA_W-1:0]  lo
);

    logic [DATA_W-1:0] rs_val, rt_val, sext_imm, op_b, alu_result;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic [4:0]        rd, rt, dest_reg;
    logic              reg_write, mem_read, mem_write, alu_src, mem_to_reg, reg_dst;
    logic              unused_rs;

    assign rs_val     = idex[IDEX_RS_VAL +: DATA_W];
    assign rt_val     = idex[IDEX_RT_VAL +: DATA_W];
    assign alu_op     = idex[IDEX_ALUOP +: 2];
    assign funct      = idex[IDEX_FUNCT +: 6];
    assign rd         = idex[IDEX_RD +: 5];
    assign reg_write  = idex[IDEX_REGWRITE];
    assign mem_read   = idex[IDEX_MEMREAD];
    assign mem_write  = idex[IDEX_MEMWRITE];
    assign sext_imm   = idex[IDEX_IMM +: DATA_W];
    assign rt         = idex[IDEX_RT +: 5];
    assign alu_src    = idex[IDEX_ALUSRC];
    assign mem_to_reg = idex[IDEX_MEMTOREG];
    assign reg_dst    = idex[IDEX_REGDST];
    assign unused_rs  = ^idex[IDEX_RS +: 5];

    assign op_b     = alu_src ? sext_imm : rt_val;
    assign dest_reg = reg_dst ? rd : rt;

    logic              is_multu, mul_busy, mul_done, done_q, bubble;
    logic [DATA_W-1:0] mul_hi, mul_lo, hi_q, lo_q;

    assign is_multu = (alu_op == ALUOP_RTYPE) && (funct == FUNCT_MULTU);

    multu_seq #(
        .DATA_W(DATA_W)
    ) u_multu (
        .clock (clock),
        .rst   (rst),
        .start (is_multu),
        .a     (rs_val),
        .b     (rt_val),
        .busy  (mul_busy),
        .done  (mul_done),
        .hi_out(mul_hi),
        .lo_out(mul_lo)
    );

    // done_q marks the DONE cycle: the held MULTU must not restart and still issues a bubble.
    assign ex_stall = rst & (mul_busy | (is_multu & ~done_q));
    assign bubble   = ex_stall | done_q;

    always_comb begin
        alu_result = '0;
        unique case (alu_op)
            ALUOP_ADD: alu_result = rs_val + op_b;
            ALUOP_SUB: alu_result = rs_val - op_b;
            ALUOP_OR:  alu_result = rs_val | op_b;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD:  alu_result = rs_val + op_b;
                    FUNCT_SUB:  alu_result = rs_val - op_b;
                    FUNCT_AND:  alu_result = rs_val & op_b;
                    FUNCT_OR:   alu_result = rs_val | op_b;
                    FUNCT_SLT:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(rs_val) < $signed(op_b))};
                    FUNCT_SLL:  alu_result = rt_val << sext_imm[10:6];
                    FUNCT_MFHI: alu_result = hi_q;
                    FUNCT_MFLO: alu_result = lo_q;
                    default:    alu_result = '0;
                endcase
            end
            default: alu_result = '0;
        endcase
    end

    logic [EXMEM_W-1:0] exmem_d, exmem_q;
    logic [31:0]        exmem_instr_d, exmem_instr_q;

    always_comb begin
        exmem_d       = '0;
        exmem_instr_d = '0;
        if (!bubble) begin
            exmem_d[EXMEM_RESULT +: DATA_W] = alu_result;
            exmem_d[EXMEM_STORE +: DATA_W]  = rt_val;
            exmem_d[EXMEM_DEST +: 5]        = dest_reg;
            exmem_d[EXMEM_REGWRITE]         = reg_write;
            exmem_d[EXMEM_MEMREAD]          = mem_read;
            exmem_d[EXMEM_MEMWRITE]         = mem_write;
            exmem_d[EXMEM_MEMTOREG]         = mem_to_reg;
            exmem_d[EXMEM_ZERO]             = (alu_result == '0);
            exmem_instr_d                   = idex_instruction;
        end
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            exmem_q       <= '0;
            exmem_instr_q <= '0;
            done_q        <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
        end else begin
            exmem_q       <= exmem_d;
            exmem_instr_q <= exmem_instr_d;
            done_q        <= mul_done;
            if (mul_done) begin
                hi_q <= mul_hi;
                lo_q <= mul_lo;
            end
        end
    end

    assign exmem             = exmem_q;
    assign exmem_instruction = exmem_instr_q;
    assign hi                = hi_q;
    assign lo                = lo_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed cases plus randomized instructions checked
// against an arithmetic reference model of the execute stage and HI/LO.
module tb_ex_mem_stage;

    logic         clock = 1'b0;
    logic         rst;
    logic [124:0] idex;
    logic [31:0]  idex_instruction;
    logic [73:0]  exmem;
    logic [31:0]  exmem_instruction;
    logic         ex_stall;
    logic [31:0]  hi, lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    always #5 clock = ~clock;

    ex_mem_stage dut (
        .clock            (clock),
        .rst              (rst),
        .idex             (idex),
        .idex_instruction (idex_instruction),
        .exmem            (exmem),
        .exmem_instruction(exmem_instruction),
        .ex_stall         (ex_stall),
        .hi               (hi),
        .lo               (lo)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // ctl = {RegDst, MemtoReg, ALUSrc, MemWrite, MemRead, RegWrite}
    function automatic logic [124:0] mk(input logic [31:0] rsv, input logic [31:0] rtv,
                                        input logic [1:0] op, input logic [5:0] fn,
                                        input logic [4:0] rd, input logic [4:0] rt,
                                        input logic [31:0] imm, input logic [5:0] ctl);
        logic [124:0] b;
        b           = '0;
        b[31:0]     = rsv;
        b[63:32]    = rtv;
        b[65:64]    = op;
        b[71:66]    = fn;
        b[76:72]    = rd;
        b[77]       = ctl[0];
        b[78]       = ctl[1];
        b[79]       = ctl[2];
        b[111:80]   = imm;
        b[116:112]  = rt;
        b[117]      = ctl[3];
        b[118]      = ctl[4];
        b[119]      = ctl[5];
        b[124:120]  = 5'd7;
        return b;
    endfunction

    function automatic bit is_mul(input logic [124:0] b);
        return (b[65:64] == 2'b10) && (b[71:66] == 6'h19);
    endfunction

    function automatic logic [73:0] model_exmem(input logic [124:0] b, input logic [31:0] h,
                                                input logic [31:0] l);
        logic [31:0] a, t, imm, opb, r;
        logic [4:0]  dst;
        a   = b[31:0];
        t   = b[63:32];
        imm = b[111:80];
        opb = b[117] ? imm : t;
        case (b[65:64])
            2'b00: r = a + opb;
            2'b01: r = a - opb;
            2'b11: r = a | opb;
            default: begin
                case (b[71:66])
                    6'h20:   r = a + opb;
                    6'h22:   r = a - opb;
                    6'h24:   r = a & opb;
                    6'h25:   r = a | opb;
                    6'h2A:   r = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
                    6'h00:   r = t << imm[10:6];
                    6'h10:   r = h;
                    6'h12:   r = l;
                    default: r = 32'd0;
                endcase
            end
        endcase
        dst = b[119] ? b[76:72] : b[116:112];
        return {(r == 32'd0), b[118], b[79], b[78], b[77], dst, t, r};
    endfunction

    // Called shortly after a rising edge; returns shortly after the edge that retires b.
    task automatic issue(input logic [124:0] b, input logic [31:0] ins);
        logic [73:0] exp;
        logic [63:0] prod;
        int          n;
        idex             = b;
        idex_instruction = ins;
        #1;
        if (is_mul(b)) begin
            check("multu_stall_start", ex_stall, 1'b1);
            n = 0;
            while (ex_stall && n < 100) begin
                @(posedge clock);
                #1;
                n++;
                check("multu_bubble", {exmem_instruction, exmem}, '0);
                // Upstream holds ID/EX, but the operand values must not matter once busy.
                if (n >= 1 && n <= 31) idex[63:0] = {$urandom, $urandom};
                else idex = b;
                #1;
            end
            check("multu_stall_len", n, 33);
            prod     = {32'd0, b[31:0]} * {32'd0, b[63:32]};
            model_hi = prod[63:32];
            model_lo = prod[31:0];
            check("multu_hi", hi, model_hi);
            check("multu_lo", lo, model_lo);
            @(posedge clock);
            #1;
            check("multu_done_bubble", {exmem_instruction, exmem}, '0);
        end else begin
            check("no_stall", ex_stall, 1'b0);
            exp = model_exmem(b, model_hi, model_lo);
            @(posedge clock);
            #1;
            check("exmem", exmem, exp);
            check("exmem_instr", exmem_instruction, ins);
            check("hi_hold", hi, model_hi);
            check("lo_hold", lo, model_lo);
        end
    endtask

    initial begin
        logic [124:0] b;
        logic [1:0]   op;
        logic [5:0]   fn;
        int           k;
        int           n_mul;

        rst              = 1'b0;
        idex             = '0;
        idex_instruction = '0;
        #12;
        check("rst_exmem", exmem, '0);
        check("rst_instr", exmem_instruction, '0);
        check("rst_hi", hi, '0);
        check("rst_lo", lo, '0);
        check("rst_stall", ex_stall, 1'b0);
        @(negedge clock);
        rst = 1'b1;
        @(posedge clock);
        #1;

        // ADD wraps into the sign bit
        issue(mk(32'h7FFFFFFF, 32'h1, 2'b10, 6'h20, 5'd5, 5'd2, 32'h0, 6'b100001), 32'h00A1_0020);
        check("t1_result", exmem[31:0], 32'h80000000);
        check("t1_dest", exmem[68:64], 5'd5);
        check("t1_regwrite", exmem[69], 1'b1);
        check("t1_zero", exmem[73], 1'b0);

        issue(mk(32'hFFFFFFFF, 32'h1, 2'b10, 6'h2A, 5'd4, 5'd1, 32'h0, 6'b100001), 32'h1);
        check("t2_slt", exmem[31:0], 32'd1);
        issue(mk(32'h3, 32'h3, 2'b01, 6'h00, 5'd0, 5'd3, 32'h0, 6'b000000), 32'h2);
        check("t2_zero", exmem[73], 1'b1);

        issue(mk(32'h100, 32'h1234_5678, 2'b00, 6'h00, 5'd0, 5'd9, 32'hFFFFFFFC, 6'b011011),
              32'h8C09_FFFC);
        check("t3_addr", exmem[31:0], 32'hFC);
        check("t3_dest", exmem[68:64], 5'd9);
        check("t3_memread", exmem[70], 1'b1);

        issue(mk(32'hFFFFFFFF, 32'h2, 2'b10, 6'h19, 5'd0, 5'd2, 32'h0, 6'b100001), 32'h19);
        check("t4_hi", hi, 32'h1);
        check("t4_lo", lo, 32'hFFFFFFFE);
        issue(mk(32'h0, 32'h0, 2'b10, 6'h10, 5'd8, 5'd0, 32'h0, 6'b100001), 32'h10);
        check("t4_mfhi", exmem[31:0], 32'h1);
        issue(mk(32'h0, 32'h0, 2'b10, 6'h12, 5'd8, 5'd0, 32'h0, 6'b100001), 32'h12);
        check("t4_mflo", exmem[31:0], 32'hFFFFFFFE);

        // Async reset in the middle of a multiply
        idex = mk(32'hDEADBEEF, 32'h1234, 2'b10, 6'h19, 5'd0, 5'd0, 32'h0, 6'b100001);
        #1;
        repeat (11) @(posedge clock);
        #3;
        check("t5_stall_pre", ex_stall, 1'b1);
        rst = 1'b0;
        #1;
        check("t5_exmem", exmem, '0);
        check("t5_instr", exmem_instruction, '0);
        check("t5_hi", hi, '0);
        check("t5_lo", lo, '0);
        check("t5_stall", ex_stall, 1'b0);
        model_hi = '0;
        model_lo = '0;
        idex     = '0;
        @(negedge clock);
        rst = 1'b1;
        @(posedge clock);
        #1;
        issue(mk(32'd3, 32'd4, 2'b10, 6'h19, 5'd0, 5'd0, 32'h0, 6'b100001), 32'h19);
        check("t5_lo_after", lo, 32'd12);
        check("t5_hi_after", hi, 32'd0);

        issue(mk(32'h0, 32'h1, 2'b10, 6'h00, 5'd3, 5'd1, 32'd31 << 6, 6'b100001), 32'h7C0);
        check("t6_sll", exmem[31:0], 32'h80000000);
        issue(mk(32'h55, 32'h66, 2'b10, 6'h3F, 5'd3, 5'd1, 32'h0, 6'b100001), 32'h3F);
        check("t6_unlisted", exmem[31:0], 32'h0);

        n_mul = 0;
        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            k  = $urandom_range(0, 9);
            case (k)
                0:       fn = 6'h20;
                1:       fn = 6'h22;
                2:       fn = 6'h24;
                3:       fn = 6'h25;
                4:       fn = 6'h2A;
                5:       fn = 6'h00;
                6:       fn = 6'h10;
                7:       fn = 6'h12;
                8:       fn = (n_mul < 3) ? 6'h19 : 6'h20;
                default: fn = 6'h3C | 6'($urandom_range(0, 3));
            endcase
            b = mk($urandom, $urandom, op, fn, 5'($urandom), 5'($urandom), $urandom,
                   6'($urandom));
            if (i % 5 == 0) begin
                b[63:32] = b[31:0];
                b[117]   = 1'b0;
            end
            if (is_mul(b)) n_mul++;
            issue(b, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
